// File: rtl/mips_cpu_mem_arbiter_if.sv
// Bus bundle between the CPU fetch/data ports, the shared memory and the arbiter.
// The slave modport is the arbiter's view; master is the CPU/memory environment's view.
interface mips_cpu_mem_arbiter_if;
  logic        instr_req;
  logic [31:0] instr_address;
  logic [31:0] instr_readdata;
  logic        instr_valid;

  logic        data_read;
  logic        data_write;
  logic [31:0] data_address;
  logic [31:0] data_writedata;
  logic [3:0]  data_byteenable;
  logic [31:0] data_readdata;
  logic        data_valid;

  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic [3:0]  mem_byteenable;
  logic        mem_waitrequest;
  logic [31:0] mem_readdata;

  logic        busy;

  modport slave (
    input  instr_req, instr_address,
    output instr_readdata, instr_valid,
    input  data_read, data_write, data_address, data_writedata, data_byteenable,
    output data_readdata, data_valid,
    output mem_address, mem_read, mem_write, mem_writedata, mem_byteenable,
    input  mem_waitrequest, mem_readdata,
    output busy
  );

  modport master (
    output instr_req, instr_address,
    input  instr_readdata, instr_valid,
    output data_read, data_write, data_address, data_writedata, data_byteenable,
    input  data_readdata, data_valid,
    input  mem_address, mem_read, mem_write, mem_writedata, mem_byteenable,
    output mem_waitrequest, mem_readdata,
    input  busy
  );
endinterface

// File: rtl/mips_cpu_mem_arbiter.sv
// Arbitrates CPU instruction fetches and data loads/stores onto one shared memory port.
// Define MIPS_CPU_MEM_ARB_ROUND_ROBIN_EN for round-robin instead of fixed DATA priority.
module mips_cpu_mem_arbiter (
  input logic                    clk,
  input logic                    reset,
  mips_cpu_mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StInstr, StData} state_e;

  state_e      state_q, state_d;
  logic [31:0] mem_address_q, mem_address_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic [31:0] mem_writedata_q, mem_writedata_d;
  logic [3:0]  mem_byteenable_q, mem_byteenable_d;
  logic [31:0] instr_readdata_q, instr_readdata_d;
  logic [31:0] data_readdata_q, data_readdata_d;
  logic        instr_valid_q, instr_valid_d;
  logic        data_valid_q, data_valid_d;

  logic instr_elig;
  logic data_elig;
  logic grant_data;

`ifdef MIPS_CPU_MEM_ARB_ROUND_ROBIN_EN
  logic last_data_q, last_data_d;
`endif

  // A requester whose valid is high this cycle is still holding its old request.
  always_comb begin
    instr_elig = bus.instr_req & ~instr_valid_q;
    data_elig  = (bus.data_read | bus.data_write) & ~data_valid_q;
`ifdef MIPS_CPU_MEM_ARB_ROUND_ROBIN_EN
    grant_data = data_elig & (~instr_elig | ~last_data_q);
`else
    grant_data = data_elig;
`endif
  end

  always_comb begin
    state_d          = state_q;
    mem_address_d    = mem_address_q;
    mem_read_d       = mem_read_q;
    mem_write_d      = mem_write_q;
    mem_writedata_d  = mem_writedata_q;
    mem_byteenable_d = mem_byteenable_q;
    instr_readdata_d = instr_readdata_q;
    data_readdata_d  = data_readdata_q;
    instr_valid_d    = 1'b0;
    data_valid_d     = 1'b0;
`ifdef MIPS_CPU_MEM_ARB_ROUND_ROBIN_EN
    last_data_d      = last_data_q;
`endif

    unique case (state_q)
      StIdle: begin
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        if (grant_data) begin
          state_d          = StData;
          mem_address_d    = bus.data_address;
          mem_writedata_d  = bus.data_writedata;
          mem_byteenable_d = bus.data_byteenable;
          // A simultaneous read+write is served as a write only.
          mem_write_d      = bus.data_write;
          mem_read_d       = ~bus.data_write;
`ifdef MIPS_CPU_MEM_ARB_ROUND_ROBIN_EN
          last_data_d      = 1'b1;
`endif
        end else if (instr_elig) begin
          state_d          = StInstr;
          mem_address_d    = bus.instr_address;
          mem_byteenable_d = 4'hF;
          mem_read_d       = 1'b1;
          mem_write_d      = 1'b0;
`ifdef MIPS_CPU_MEM_ARB_ROUND_ROBIN_EN
          last_data_d      = 1'b0;
`endif
        end
      end
      StInstr: begin
        if (!bus.mem_waitrequest) begin
          state_d          = StIdle;
          mem_read_d       = 1'b0;
          mem_write_d      = 1'b0;
          instr_readdata_d = bus.mem_readdata;
          instr_valid_d    = 1'b1;
        end
      end
      StData: begin
        if (!bus.mem_waitrequest) begin
          state_d      = StIdle;
          mem_read_d   = 1'b0;
          mem_write_d  = 1'b0;
          data_valid_d = 1'b1;
          if (mem_read_q) begin
            data_readdata_d = bus.mem_readdata;
          end
        end
      end
      default: begin
        state_d     = StIdle;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= StIdle;
      mem_address_q    <= '0;
      mem_read_q       <= 1'b0;
      mem_write_q      <= 1'b0;
      mem_writedata_q  <= '0;
      mem_byteenable_q <= '0;
      instr_readdata_q <= '0;
      data_readdata_q  <= '0;
      instr_valid_q    <= 1'b0;
      data_valid_q     <= 1'b0;
`ifdef MIPS_CPU_MEM_ARB_ROUND_ROBIN_EN
      last_data_q      <= 1'b0;
`endif
    end else begin
      state_q          <= state_d;
      mem_address_q    <= mem_address_d;
      mem_read_q       <= mem_read_d;
      mem_write_q      <= mem_write_d;
      mem_writedata_q  <= mem_writedata_d;
      mem_byteenable_q <= mem_byteenable_d;
      instr_readdata_q <= instr_readdata_d;
      data_readdata_q  <= data_readdata_d;
      instr_valid_q    <= instr_valid_d;
      data_valid_q     <= data_valid_d;
`ifdef MIPS_CPU_MEM_ARB_ROUND_ROBIN_EN
      last_data_q      <= last_data_d;
`endif
    end
  end

  assign bus.mem_address    = mem_address_q;
  assign bus.mem_read       = mem_read_q;
  assign bus.mem_write      = mem_write_q;
  assign bus.mem_writedata  = mem_writedata_q;
  assign bus.mem_byteenable = mem_byteenable_q;
  assign bus.instr_readdata = instr_readdata_q;
  assign bus.data_readdata  = data_readdata_q;
  assign bus.instr_valid    = instr_valid_q;
  assign bus.data_valid     = data_valid_q;
  assign bus.busy           = (state_q != StIdle);

endmodule

// File: tb/tb_mips_cpu_mem_arbiter.sv
// Directed bench for mips_cpu_mem_arbiter: one task per scenario, inline checks.
module tb_mips_cpu_mem_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] rd_word;
  logic        both_valid_seen = 1'b0;
  int          n_tests = 0;
  int          n_fail = 0;

  mips_cpu_mem_arbiter_if bus ();

  mips_cpu_mem_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  assign bus.mem_readdata = rd_word;

  always @(negedge clk) begin
    if (bus.instr_valid === 1'b1 && bus.data_valid === 1'b1) both_valid_seen = 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.instr_req       = 1'b0;
    bus.instr_address   = '0;
    bus.data_read       = 1'b0;
    bus.data_write      = 1'b0;
    bus.data_address    = '0;
    bus.data_writedata  = '0;
    bus.data_byteenable = '0;
    bus.mem_waitrequest = 1'b0;
    rd_word             = '0;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    tick();
    tick();
    n_tests++;
    if ({bus.mem_read, bus.mem_write, bus.mem_address, bus.mem_writedata, bus.mem_byteenable,
         bus.instr_readdata, bus.data_readdata, bus.instr_valid, bus.data_valid, bus.busy}
        !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got nonzero outputs mem_read=%b addr=%h busy=%b, expected 0",
               bus.mem_read, bus.mem_address, bus.busy);
    end
    reset = 1'b0;
    tick();
    chk("idle_no_strobe", {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
  endtask

  task automatic test_fetch_alone();
    rd_word           = 32'h24020005;
    bus.instr_req     = 1'b1;
    bus.instr_address = 32'hBFC00000;
    tick();
    chk("fetch_mem_read", {31'd0, bus.mem_read}, 32'd1);
    chk("fetch_mem_write", {31'd0, bus.mem_write}, 32'd0);
    chk("fetch_mem_address", bus.mem_address, 32'hBFC00000);
    chk("fetch_byteenable", {28'd0, bus.mem_byteenable}, 32'hF);
    chk("fetch_busy", {31'd0, bus.busy}, 32'd1);
    tick();
    chk("fetch_instr_valid", {31'd0, bus.instr_valid}, 32'd1);
    chk("fetch_instr_readdata", bus.instr_readdata, 32'h24020005);
    chk("fetch_strobe_dropped", {31'd0, bus.mem_read}, 32'd0);
    chk("fetch_no_data_valid", {31'd0, bus.data_valid}, 32'd0);
    bus.instr_req = 1'b0;
    tick();
    chk("fetch_valid_one_cycle", {31'd0, bus.instr_valid}, 32'd0);
    chk("fetch_no_refetch", {31'd0, bus.mem_read}, 32'd0);
  endtask

  task automatic test_simultaneous();
    rd_word             = 32'hCAFE0001;
    bus.instr_req       = 1'b1;
    bus.instr_address   = 32'h00000400;
    bus.data_read       = 1'b1;
    bus.data_address    = 32'h00002000;
    bus.data_byteenable = 4'b0110;
    tick();
    chk("sim_first_addr_data", bus.mem_address, 32'h00002000);
    chk("sim_first_read", {31'd0, bus.mem_read}, 32'd1);
    chk("sim_first_be", {28'd0, bus.mem_byteenable}, 32'h6);
    tick();
    chk("sim_data_valid", {31'd0, bus.data_valid}, 32'd1);
    chk("sim_data_readdata", bus.data_readdata, 32'hCAFE0001);
    chk("sim_no_instr_valid_yet", {31'd0, bus.instr_valid}, 32'd0);
    bus.data_read = 1'b0;
    rd_word       = 32'hCAFE0002;
    tick();
    chk("sim_second_addr_instr", bus.mem_address, 32'h00000400);
    chk("sim_second_be", {28'd0, bus.mem_byteenable}, 32'hF);
    chk("sim_data_valid_once", {31'd0, bus.data_valid}, 32'd0);
    tick();
    chk("sim_instr_valid", {31'd0, bus.instr_valid}, 32'd1);
    chk("sim_instr_readdata", bus.instr_readdata, 32'hCAFE0002);
    bus.instr_req = 1'b0;
    tick();
    chk("sim_all_done", {30'd0, bus.instr_valid, bus.data_valid}, 32'd0);
  endtask

  task automatic test_store_wait();
    rd_word             = 32'h12345678;
    bus.data_write      = 1'b1;
    bus.data_address    = 32'h00001000;
    bus.data_writedata  = 32'hDEADBEEF;
    bus.data_byteenable = 4'b0011;
    bus.mem_waitrequest = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("store_mem_write", {30'd0, bus.mem_write, bus.mem_read}, 32'd2);
      chk("store_mem_address", bus.mem_address, 32'h00001000);
      chk("store_mem_writedata", bus.mem_writedata, 32'hDEADBEEF);
      chk("store_mem_be", {28'd0, bus.mem_byteenable}, 32'h3);
      chk("store_no_early_valid", {31'd0, bus.data_valid}, 32'd0);
      if (k == 3) bus.mem_waitrequest = 1'b0;
    end
    tick();
    chk("store_data_valid", {31'd0, bus.data_valid}, 32'd1);
    chk("store_strobe_dropped", {31'd0, bus.mem_write}, 32'd0);
    chk("store_readdata_kept", bus.data_readdata, 32'hCAFE0001);
    bus.data_write = 1'b0;
    tick();
    chk("store_valid_one_cycle", {31'd0, bus.data_valid}, 32'd0);
  endtask

  task automatic test_held_instr();
    rd_word           = 32'h11111111;
    bus.instr_req     = 1'b1;
    bus.instr_address = 32'h00000100;
    tick();
    chk("held_first_read", {31'd0, bus.mem_read}, 32'd1);
    tick();
    chk("held_first_valid", {31'd0, bus.instr_valid}, 32'd1);
    chk("held_no_read_in_valid", {31'd0, bus.mem_read}, 32'd0);
    rd_word = 32'h22222222;
    tick();
    chk("held_idle_after_valid", {30'd0, bus.busy, bus.mem_read}, 32'd0);
    chk("held_valid_dropped", {31'd0, bus.instr_valid}, 32'd0);
    tick();
    chk("held_second_read", {30'd0, bus.busy, bus.mem_read}, 32'd3);
    chk("held_second_addr", bus.mem_address, 32'h00000100);
    bus.instr_req = 1'b0;
    tick();
    chk("held_second_valid", {31'd0, bus.instr_valid}, 32'd1);
    chk("held_second_data", bus.instr_readdata, 32'h22222222);
    tick();
  endtask

  task automatic test_arbitration_repeat();
    logic exp_data;
    for (int it = 0; it < 4; it++) begin
`ifdef MIPS_CPU_MEM_ARB_ROUND_ROBIN_EN
      exp_data = ((it % 2) == 0);
`else
      exp_data = 1'b1;
`endif
      bus.instr_req     = 1'b1;
      bus.instr_address = 32'h00000500;
      bus.data_read     = 1'b1;
      bus.data_address  = 32'h00003000;
      tick();
      chk("arb_grant_addr", bus.mem_address, exp_data ? 32'h00003000 : 32'h00000500);
      tick();
      chk("arb_winner_valid", {30'd0, bus.data_valid, bus.instr_valid},
          exp_data ? 32'd2 : 32'd1);
      bus.instr_req = 1'b0;
      bus.data_read = 1'b0;
      tick();
      chk("arb_loser_dropped", {30'd0, bus.busy, bus.mem_read}, 32'd0);
    end
  endtask

  task automatic test_reset_mid();
    bus.data_read       = 1'b1;
    bus.data_address    = 32'h00004000;
    bus.mem_waitrequest = 1'b1;
    tick();
    chk("rstmid_granted", {30'd0, bus.busy, bus.mem_read}, 32'd3);
    tick();
    reset = 1'b1;
    tick();
    n_tests++;
    if ({bus.mem_read, bus.mem_write, bus.mem_address, bus.mem_writedata, bus.mem_byteenable,
         bus.instr_readdata, bus.data_readdata, bus.instr_valid, bus.data_valid, bus.busy}
        !== '0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: got mem_read=%b addr=%h busy=%b rd=%h, expected all 0",
               bus.mem_read, bus.mem_address, bus.busy, bus.data_readdata);
    end
    reset               = 1'b0;
    bus.data_read       = 1'b0;
    bus.mem_waitrequest = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rstmid_no_valid", {30'd0, bus.data_valid, bus.busy}, 32'd0);
    end
  endtask

  task automatic test_exclusive_valid();
    chk("exclusive_valids", {31'd0, both_valid_seen}, 32'd0);
  endtask

  initial begin
    test_reset();
    test_fetch_alone();
    test_simultaneous();
    test_store_wait();
    test_held_instr();
    test_arbitration_repeat();
    test_reset_mid();
    test_exclusive_valid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mips_cpu_mem_arbiter.md
MIPS_CPU_MEM_ARBITER -- requirements
Module: mips_cpu_mem_arbiter

Interface
REQ-001 The block SHALL have these ports:
- clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- instr_req  in  1  fetch request; held high until instr_valid.
- instr_address  in  32  fetch byte address.
- instr_readdata  out  32  registered fetch data.
- instr_valid  out  1  one-cycle pulse; fetch complete.
- data_read  in  1  load request; held high until data_valid.
- data_write  in  1  store request; held high until data_valid.
- data_address  in  32  load/store byte address.
- data_writedata  in  32  store data.
- data_byteenable  in  4  store/load byte lanes.
- data_readdata  out  32  registered load data.
- data_valid  out  1  one-cycle pulse; data access complete.
- mem_address  out  32  shared memory address (registered).
- mem_read  out  1  shared memory read strobe (registered).
- mem_write  out  1  shared memory write strobe (registered).
- mem_writedata  out  32  shared memory write data (registered).
- mem_byteenable  out  4  shared memory byte lanes (registered); 4'hF for fetches.
- mem_waitrequest  in  1  memory stall; transfer completes in a cycle where strobe high and waitrequest low.
- mem_readdata  in  32  memory read data, valid when waitrequest low.
- busy  out  1  high in any state other than IDLE.

Function
REQ-002 The FSM SHALL have states IDLE, INSTR, DATA.
REQ-003 IDLE: with no eligible request, the block SHALL stay in IDLE with mem_read=0 and mem_write=0.
REQ-004 IDLE, eligible request present: the block SHALL grant one requester; on that edge it SHALL latch address/writedata/byteenable into mem_* and SHALL enter INSTR or DATA.
REQ-005 Grant to INSTR SHALL drive mem_read=1, mem_write=0, mem_byteenable=4'hF.
REQ-006 Grant to DATA SHALL drive mem_write=1 if data_write, else mem_read=1; data_read and data_write both high SHALL be served as a write only.
REQ-007 INSTR/DATA with mem_waitrequest=1: all mem_* outputs SHALL hold unchanged.
REQ-008 INSTR/DATA with mem_waitrequest=0: on that edge the block SHALL deassert mem_read/mem_write, capture mem_readdata into the granted requester's readdata register (reads only; writes leave it unchanged), pulse that requester's valid for exactly the next cycle, and return to IDLE.
REQ-009 Minimum latency SHALL be 2 cycles: request seen in IDLE at cycle N, strobe high in cycle N+1, valid high in cycle N+2 with zero wait states.
REQ-010 In the cycle a requester's valid is high, its request SHALL be masked from arbitration; this prevents a duplicate access on a held request.
REQ-011 Requests deasserted before grant SHALL be ignored; deassertion after grant SHALL NOT abort the transfer.
REQ-012 Request inputs changing while granted SHALL NOT affect mem_* outputs.
REQ-013 Default arbitration SHALL be fixed priority: DATA over INSTR.
REQ-014 Only one of instr_valid or data_valid SHALL be high in any cycle.

Reset
REQ-015 While reset is high at a rising edge, the block SHALL enter IDLE. On that edge, every output SHALL become zero: mem_read, mem_write, mem_address, mem_writedata, mem_byteenable, instr_readdata, data_readdata, instr_valid, data_valid, busy.
REQ-016 Reset mid-transfer SHALL abandon the transfer, with no valid pulse issued for it.
REQ-017 Reset SHALL clear the round-robin history bit to "last grant = INSTR" when that feature is compiled in.

Configuration
REQ-018 The feature macro SHALL be MIPS_CPU_MEM_ARB_ROUND_ROBIN_EN.
- Defined: simultaneous eligible requests in IDLE SHALL be granted to the requester not granted last. History updates on every grant.
- Undefined: the fixed DATA priority of REQ-013 applies, and no history register exists.

Verification
REQ-019 The bench SHALL cover these scenarios:
- Fetch alone: instr_req=1, instr_address=32'hBFC00000, readdata=32'h24020005, waitrequest=0 -> mem_read=1 @N+1 with address 32'hBFC00000, be=4'hF; instr_valid=1, instr_readdata=32'h24020005 @N+2.
- Store with 3 wait states: data_write=1, addr=32'h00001000, wd=32'hDEADBEEF, be=4'b0011 -> mem_write held 4 cycles with stable fields; data_valid exactly 1 cycle after waitrequest drops; data_readdata unchanged.
- Simultaneous instr_req and data_read, macro undefined -> DATA granted first, then INSTR; both valids pulse once each.
- Simultaneous requests repeated 4 times, macro defined -> grants alternate DATA, INSTR, DATA, INSTR.
- Reset asserted in DATA with waitrequest=1 -> next cycle IDLE, all outputs 0, no data_valid.
- Held instr_req across its instr_valid cycle -> second fetch starts in the cycle after valid, never in the valid cycle itself.
